// File: rtl/truth_table_sweeper.sv
// Sweeps every WIDTH-bit code through an external combinational decode stage and
// records its single-bit response in a 2^WIDTH-entry truth table, with a population count.
module truth_table_sweeper #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    func_in_i,
  output logic [WIDTH-1:0]        code_out_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    result_valid_o,
  output logic [(2**WIDTH)-1:0]   table_out_o,
  output logic [WIDTH:0]          ones_count_o
);

  localparam int unsigned DEPTH = 2 ** WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [WIDTH-1:0] LAST_CODE   = {WIDTH{1'b1}};
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] code_q,   code_d;
  logic [3:0]       settle_q, settle_d;
  logic [DEPTH-1:0] table_q,  table_d;
  logic [WIDTH:0]   ones_q,   ones_d;
  logic             valid_q,  valid_d;

  // Abort overrides every state; the partial table is left in place for debug.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    settle_d = settle_q;
    table_d  = table_q;
    ones_d   = ones_q;
    valid_d  = valid_q;
    if (abort_i) begin
      state_d  = IDLE;
      code_d   = '0;
      settle_d = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            table_d  = '0;
            ones_d   = '0;
            code_d   = '0;
            settle_d = '0;
            valid_d  = 1'b0;
            state_d  = DRIVE;
          end
        end
        DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = SAMPLE;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        SAMPLE: begin
          table_d[code_q] = func_in_i;
          ones_d          = ones_q + (WIDTH+1)'(func_in_i);
          // Terminal compare before the increment so the last code is sampled once.
          if (code_q == LAST_CODE) begin
            valid_d = 1'b1;
            state_d = FINISH;
          end else begin
            code_d   = code_q + 1'b1;
            settle_d = '0;
            state_d  = DRIVE;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      settle_q <= '0;
      table_q  <= '0;
      ones_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      ones_q   <= ones_d;
      valid_q  <= valid_d;
    end
  end

  assign code_out_o     = code_q;
  assign busy_o         = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done_o         = (state_q == FINISH);
  assign result_valid_o = valid_q;
  assign table_out_o    = table_q;
  assign ones_count_o   = ones_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential exerciser for a WIDTH-input, 1-output combinational decode stage.
- Drives every input code 0..2^WIDTH-1 onto that stage and captures its response into a 2^WIDTH-bit truth-table vector.
- Counts the asserted entries and reports completion with a done/valid handshake.
- Sits directly upstream of the decode (code_out feeds its input bus) and downstream of it (func_in takes its output). Used for on-board self-check against a golden vector.

Parameters:
- WIDTH, 5, input width of the decode stage; table has 2^WIDTH entries.
- SETTLE, 1, cycles code_out is held before sampling func_in; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- abort  input  1  synchronous abort; highest priority after reset.
- func_in  input  1  decode-stage output for the currently driven code.
- code_out  output  WIDTH  registered code driven to the decode-stage input.
- busy  output  1  high in DRIVE or SAMPLE.
- done  output  1  single-cycle pulse at sweep completion.
- result_valid  output  1  table_out/ones_count hold a complete sweep.
- table_out  output  2^WIDTH  bit i = func_in sampled while code_out==i.
- ones_count  output  WIDTH+1  number of 1 bits in table_out.

Behaviour:
- Reset (rst_n low, async): state=IDLE; code_out=0, busy=0, done=0, result_valid=0, table_out=0, ones_count=0, settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - start=1 → clear table_out and ones_count, code_out=0, result_valid=0 → DRIVE.
  - start=0 → hold all outputs.
- DRIVE: code_out stable. The settle counter counts 0..SETTLE-1; on the last count → SAMPLE.
- SAMPLE (one cycle):
  - table_out[code_out] <= func_in; ones_count += func_in.
  - If code_out == 2^WIDTH-1 → FINISH; else code_out+1, settle counter=0 → DRIVE.
- FINISH (one cycle): done=1, result_valid=1 → IDLE. code_out stays at 2^WIDTH-1 until the next start.
- Latency: start sampled at edge N; done high in cycle N + 2^WIDTH*(SETTLE+1) + 1. Default is 65 cycles after start.
- Every table bit is written exactly once per sweep. Unwritten bits stay 0 (cleared at start).
- ones_count never wraps: the maximum 2^WIDTH fits in WIDTH+1 bits.
- code_out increments without wrap. The terminal compare precedes the increment, so code 2^WIDTH-1 is sampled exactly once.
- start while busy or in FINISH: ignored, with no restart or queueing.
- abort=1 in any state:
  - Next state IDLE; done not pulsed; result_valid=0.
  - table_out/ones_count keep their partial contents (debug only).
  - code_out reset to 0.
  - abort and start together in IDLE: abort wins, no sweep begins.
- rst_n asserted mid-sweep: immediate return to reset values. No partial result survives.
- func_in is treated as combinational from code_out. Any path delay must fit within SETTLE cycles.

Test Plan:
1. Bench model func_in=~code_out[0], SETTLE=1, pulse start → done at cycle 65, table_out=32'h5555_5555, ones_count=16, result_valid=1.
2. func_in tied 1 → table_out=32'hFFFF_FFFF, ones_count=32 (6'b100000, no wrap); func_in tied 0 → table_out=0, ones_count=0, done still pulses.
3. SETTLE=3, func_in=(code_out==5'd31) → done at cycle 129, table_out=32'h8000_0000, ones_count=1; check code_out holds each value exactly 3 cycles before its sample cycle.
4. start re-pulsed at cycles 10 and 40 of a running sweep → no restart, done once at cycle 65; second start after done → result_valid drops, new sweep completes identically.
5. abort at cycle 20 → IDLE next cycle, no done pulse, result_valid=0, code_out=0; abort+start in the same IDLE cycle → stays IDLE.
6. rst_n low asynchronously mid-SAMPLE (between edges) → all outputs to reset values immediately; release, then start → full correct sweep.
